// File: rtl/mem_interface_unit.sv
// Memory interface unit: turns level load/store requests from the instruction
// unit into byte-wide memory accesses. A load is one read; a store is two
// writes (low byte at addr, high byte at addr+1). Every access is guarded by a
// wait counter that aborts it and raises a sticky error if mem_ack never comes.
`timescale 1ns/1ps

module mem_interface_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        store,
  input  logic [13:0] addr,
  input  logic [15:0] result,
  output logic [7:0]  data,
  output logic        mem_done,
  output logic        mem_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_WR_LO = 3'd2;
  localparam logic [2:0] S_WR_HI = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [7:0]       wdata_hi_q,  wdata_hi_d;
  logic [7:0]       data_q,      data_d;
  logic             mem_done_q,  mem_done_d;
  logic             mem_err_q,   mem_err_d;
  logic             mem_req_q,   mem_req_d;
  logic             mem_we_q,    mem_we_d;
  logic [13:0]      mem_addr_q,  mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  // Wait-cycle count after this cycle, and whether it would reach the limit.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == TIMEOUT_VAL);

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    // NOTE: every *_d gets a default up front so no path through the case
    // leaves a variable unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    wdata_hi_d  = wdata_hi_q;
    data_d      = data_q;
    mem_done_d  = 1'b0;
    mem_err_d   = mem_err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (load) begin
          // Load wins when both requests are raised together.
          state_d    = S_RD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr;
        end else if (store) begin
          state_d     = S_WR_LO;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr;
          mem_wdata_d = result[7:0];
          wdata_hi_d  = result[15:8];
        end
      end

      S_RD: begin
        if (mem_ack) begin
          data_d     = mem_rdata;
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
          state_d    = S_DONE;
        end else if (timeout_hit) begin
          mem_err_d  = 1'b1;
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WR_LO: begin
        if (mem_ack) begin
          // High byte goes to the next address; 14-bit add wraps 0x3FFF to 0.
          cnt_d       = '0;
          mem_addr_d  = mem_addr_q + 14'd1;
          mem_wdata_d = wdata_hi_q;
          state_d     = S_WR_HI;
        end else if (timeout_hit) begin
          // Abort skips the high byte entirely.
          mem_err_d  = 1'b1;
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WR_HI: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
          state_d    = S_DONE;
        end else if (timeout_hit) begin
          mem_err_d  = 1'b1;
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DONE: begin
        // mem_done was raised on entry; it drops as we return to IDLE.
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        cnt_d     = '0;
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      // NOTE: reset is synchronous here, so it is not in the sensitivity list;
      // a reset mid-access simply lands in IDLE with no completion pulse.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wdata_hi_q  <= '0;
      data_q      <= '0;
      mem_done_q  <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdata_hi_q  <= wdata_hi_d;
      data_q      <= data_d;
      mem_done_q  <= mem_done_d;
      mem_err_q   <= mem_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign data      = data_q;
  assign mem_done  = mem_done_q;
  assign mem_err   = mem_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Bench for mem_interface_unit (TIMEOUT = 4). A directed table covers the
// named scenarios, a hand sequence covers reset inside the high-byte write,
// and randomized transactions are scored against a transaction-level model.
`timescale 1ns/1ps

module tb_mem_interface_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load, store;
  logic [13:0] addr;
  logic [15:0] result;
  logic [7:0]  data;
  logic        mem_done, mem_err, mem_req, mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;

  mem_interface_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .store     (store),
    .addr      (addr),
    .result    (result),
    .data      (data),
    .mem_done  (mem_done),
    .mem_err   (mem_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // One request plus the memory's behaviour: d0/d1 = wait cycles before ack
  // on the first/second access (>= TO means the ack never comes in time).
  typedef struct {
    logic        ld;
    logic        st;
    logic        tog;
    logic [13:0] a;
    logic [15:0] r;
    logic [7:0]  rd;
    int          d0;
    int          d1;
  } txn_t;

  // Expected outcome. done_at = negedge index (after the sampling edge) at
  // which mem_done is seen; mem_req is expected high on all earlier ones.
  typedef struct {
    int          nacc;
    logic        w0;
    logic [13:0] a0;
    logic [7:0]  wd0;
    logic        w1;
    logic [13:0] a1;
    logic [7:0]  wd1;
    logic [7:0]  data;
    logic        err;
    int          done_at;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  // Observations from the last transaction.
  int          n_acc, done_cnt, done_at, req_cycles;
  logic        ow [2];
  logic [13:0] oa [2];
  logic [7:0]  od [2];

  logic [7:0] mdl_data;
  logic       mdl_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Transaction-level reference: which accesses complete, where, with what,
  // and how many cycles the whole request takes.
  function automatic exp_t model(input txn_t t, input logic [7:0] pdata, input logic perr);
    exp_t e;
    int   c0, c1;
    e.nacc = 0; e.w0 = 1'b0; e.a0 = '0; e.wd0 = '0;
    e.w1 = 1'b0; e.a1 = '0; e.wd1 = '0;
    e.data = pdata; e.err = perr; e.done_at = 0;
    c0 = (t.d0 < TO) ? t.d0 + 1 : TO;
    c1 = (t.d1 < TO) ? t.d1 + 1 : TO;
    if (t.ld) begin
      e.done_at = c0 + 1;
      if (t.d0 < TO) begin
        e.nacc = 1; e.w0 = 1'b0; e.a0 = t.a; e.data = t.rd;
      end else e.err = 1'b1;
    end else if (t.st) begin
      if (t.d0 < TO) begin
        e.nacc = 1; e.w0 = 1'b1; e.a0 = t.a; e.wd0 = t.r[7:0];
        e.done_at = c0 + c1 + 1;
        if (t.d1 < TO) begin
          e.nacc = 2; e.w1 = 1'b1;
          e.a1 = 14'((int'(t.a) + 1) % 16384);
          e.wd1 = t.r[15:8];
        end else e.err = 1'b1;
      end else begin
        e.err = 1'b1;
        e.done_at = c0 + 1;
      end
    end
    return e;
  endfunction

  // Called at a negedge; returns at a negedge. Plays the memory side.
  task automatic run_txn(input txn_t t);
    int idx, wait_c, dly;
    load = t.ld; store = t.st; addr = t.a; result = t.r; mem_ack = 1'b0;
    @(posedge clk);
    n_acc = 0; done_cnt = 0; done_at = 0; req_cycles = 0; idx = 0; wait_c = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_done) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      if (mem_req) begin
        req_cycles++;
        dly = (idx == 0) ? t.d0 : t.d1;
        if (wait_c == dly) begin
          mem_ack = 1'b1; mem_rdata = t.rd;
          if (n_acc < 2) begin
            ow[n_acc] = mem_we; oa[n_acc] = mem_addr; od[n_acc] = mem_wdata;
          end
          n_acc++; idx++; wait_c = 0;
        end else begin
          mem_ack = 1'b0; mem_rdata = 8'($urandom); wait_c++;
        end
      end else begin
        // Stray acks outside an access must be ignored.
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
      end
      if (done_at != 0 || !t.tog) begin
        load = 1'b0; store = 1'b0;
      end else begin
        load = ~load; store = 1'($urandom); addr = 14'($urandom); result = 16'($urandom);
      end
      if (done_at != 0 && c >= done_at + 2) break;
    end
    mem_ack = 1'b0;
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".done_cnt"}, done_cnt, 1);
    check({tag, ".done_at"}, done_at, e.done_at);
    check({tag, ".req_cycles"}, req_cycles, e.done_at - 1);
    check({tag, ".n_acc"}, n_acc, e.nacc);
    for (int i = 0; i < e.nacc && i < n_acc && i < 2; i++) begin
      check({tag, $sformatf(".we%0d", i)}, ow[i], (i == 0) ? e.w0 : e.w1);
      check({tag, $sformatf(".addr%0d", i)}, oa[i], (i == 0) ? e.a0 : e.a1);
      if ((i == 0) ? e.w0 : e.w1)
        check({tag, $sformatf(".wdata%0d", i)}, od[i], (i == 0) ? e.wd0 : e.wd1);
    end
    check({tag, ".data"}, data, e.data);
    check({tag, ".mem_err"}, mem_err, e.err);
    mdl_data = e.data;
    mdl_err  = e.err;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_req"}, mem_req, 0);
    check({tag, ".mem_we"}, mem_we, 0);
    check({tag, ".mem_addr"}, mem_addr, 0);
    check({tag, ".mem_wdata"}, mem_wdata, 0);
    check({tag, ".data"}, data, 0);
    check({tag, ".mem_done"}, mem_done, 0);
    check({tag, ".mem_err"}, mem_err, 0);
  endtask

  vec_t vec [7];
  txn_t t;
  exp_t e;
  int   dn;

  initial begin
    // Directed vectors; expectations worked out by hand in sequence order.
    //          ld    st    tog   addr      result    rdata  d0 d1
    //          nacc w0 a0 wd0 w1 a1 wd1 data err done_at
    vec[0] = '{'{1'b1, 1'b0, 1'b1, 14'h0123, 16'h0000, 8'hA5, 2, 0},
               '{1, 1'b0, 14'h0123, 8'h00, 1'b0, 14'h0000, 8'h00, 8'hA5, 1'b0, 4}};
    vec[1] = '{'{1'b0, 1'b1, 1'b0, 14'h0040, 16'hBEEF, 8'h00, 0, 0},
               '{2, 1'b1, 14'h0040, 8'hEF, 1'b1, 14'h0041, 8'hBE, 8'hA5, 1'b0, 3}};
    vec[2] = '{'{1'b0, 1'b1, 1'b0, 14'h3FFF, 16'h1234, 8'h00, 0, 0},
               '{2, 1'b1, 14'h3FFF, 8'h34, 1'b1, 14'h0000, 8'h12, 8'hA5, 1'b0, 3}};
    vec[3] = '{'{1'b1, 1'b1, 1'b1, 14'h0200, 16'hFFFF, 8'h5A, 1, 0},
               '{1, 1'b0, 14'h0200, 8'h00, 1'b0, 14'h0000, 8'h00, 8'h5A, 1'b0, 3}};
    vec[4] = '{'{1'b0, 1'b1, 1'b0, 14'h1000, 16'hCAFE, 8'h00, 3, 3},
               '{2, 1'b1, 14'h1000, 8'hFE, 1'b1, 14'h1001, 8'hCA, 8'h5A, 1'b0, 9}};
    vec[5] = '{'{1'b0, 1'b1, 1'b0, 14'h0010, 16'h7788, 8'h00, 1, 4},
               '{1, 1'b1, 14'h0010, 8'h88, 1'b0, 14'h0000, 8'h00, 8'h5A, 1'b1, 7}};
    vec[6] = '{'{1'b1, 1'b0, 1'b0, 14'h0555, 16'h0000, 8'h11, 5, 0},
               '{0, 1'b0, 14'h0000, 8'h00, 1'b0, 14'h0000, 8'h00, 8'h5A, 1'b1, 5}};

    reset_n = 1'b0; load = 1'b0; store = 1'b0; addr = '0; result = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // Request raised in the first cycle after reset release.
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_txn(vec[i].t);
      compare($sformatf("vec%0d", i), vec[i].e);
    end

    // Reset while the high byte is being written.
    store = 1'b1; addr = 14'h2222; result = 16'h5566;
    @(posedge clk); @(negedge clk);
    check("rst_seq.lo_req", mem_req, 1);
    check("rst_seq.lo_we", mem_we, 1);
    check("rst_seq.lo_addr", mem_addr, 14'h2222);
    mem_ack = 1'b1; store = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_seq.hi_addr", mem_addr, 14'h2223);
    check("rst_seq.hi_wdata", mem_wdata, 8'h55);
    mem_ack = 1'b0; reset_n = 1'b0;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    check_all_zero("rst_seq");
    dn = 0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      dn += int'(mem_done) + int'(mem_req);
    end
    check("rst_seq.quiet_after", dn, 0);
    mdl_data = 8'h00; mdl_err = 1'b0;
    t = '{1'b0, 1'b1, 1'b0, 14'h3FFE, 16'hA1B2, 8'h00, 0, 1};
    run_txn(t);
    compare("rst_seq.store", model(t, mdl_data, mdl_err));

    // Randomized transactions against the reference model.
    for (int n = 0; n < 150; n++) begin
      t.ld  = 1'($urandom);
      t.st  = 1'($urandom);
      if (!t.ld && !t.st) t.st = 1'b1;
      t.tog = 1'($urandom);
      t.a   = 14'($urandom);
      if (n % 16 == 5) t.a = 14'h3FFF;
      t.r   = 16'($urandom);
      t.rd  = 8'($urandom);
      t.d0  = $urandom_range(0, 9);
      if (t.d0 > 5) t.d0 -= 6;
      t.d1  = $urandom_range(0, 9);
      if (t.d1 > 5) t.d1 -= 6;
      e = model(t, mdl_data, mdl_err);
      run_txn(t);
      compare($sformatf("rnd%0d", n), e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
